mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 107 ++++++++++
 tb/tb_mux_scan_ctrl.sv | 110 +++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: steps a 16:1 mux over enabled channels, settling DWELL cycles then sampling each.
// Ports: clk, rst_n (async active-low), start, abort, chan_en[15:0] mask, mux_out sampled bit;
//        sel[3:0] mux select, busy (SETTLE/SAMPLE), done (1-cycle pulse), result[15:0] per-channel bits.
// Parameter DWELL (1..15). Macro MUX_SCAN_CONT_EN enables continuous rescanning until abort.
module mux_scan_ctrl #(
  parameter int DWELL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] chan_en,
  input  logic        mux_out,
  output logic [3:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [15:0] result
);
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] sel_q, sel_d, cnt_q, cnt_d;
  logic [15:0] mask_q, mask_d, shadow_q, shadow_d, result_q, result_d;
  logic busy_q, busy_d, done_q, done_d;
  logic [15:0] above, sampled;
  function automatic logic [3:0] lowest(input logic [15:0] m);
    lowest = '0;
    for (int i = 15; i >= 0; i--) if (m[i]) lowest = 4'(i);
  endfunction
  // enabled channels strictly above the current select; empty at index 15 so sel never wraps
  assign above = mask_q & (16'hFFFE << sel_q);
  assign sampled = shadow_q | (16'(mux_out) << sel_q);
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    cnt_d = cnt_q;
    mask_d = mask_q;
    shadow_d = shadow_q;
    result_d = result_q;
    if (abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (start) begin
        mask_d = chan_en;
        if (|chan_en) begin
          sel_d = lowest(chan_en);
          cnt_d = '0;
          shadow_d = '0;
          state_d = SETTLE;
        end else begin
          result_d = '0;
          state_d = DONE;
        end
      end
      SETTLE: if (cnt_q == 4'(DWELL - 1)) state_d = SAMPLE;
              else cnt_d = cnt_q + 4'd1;
      SAMPLE: begin
        shadow_d = sampled;
        if (|above) begin
          sel_d = lowest(above);
          cnt_d = '0;
          state_d = SETTLE;
        end else begin
          result_d = sampled & mask_q;
          state_d = DONE;
        end
      end
      DONE: begin
`ifdef MUX_SCAN_CONT_EN
        if (|mask_q) begin
          sel_d = lowest(mask_q);
          cnt_d = '0;
          shadow_d = '0;
          state_d = SETTLE;
        end else state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
    endcase
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      shadow_q <= '0;
      result_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      cnt_q <= cnt_d;
      mask_q <= mask_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  assign sel = sel_q;
  assign busy = busy_q;
  assign done = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed checks of mux_scan_ctrl with default DWELL=2.
module tb_mux_scan_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, mux_out;
  logic [15:0] chan_en = '0, in_vec = '0, result;
  logic [3:0] sel;
  logic busy, done;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  assign mux_out = in_vec[sel];
  mux_scan_ctrl dut (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .chan_en(chan_en),
                     .mux_out(mux_out), .sel(sel), .busy(busy), .done(done), .result(result));
  task automatic kick(input logic [15:0] m, input logic [15:0] v);
    @(negedge clk);
    chan_en = m;
    in_vec = v;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic test_reset;
    #2;
    n_cmp++; if ({sel, busy, done, result} !== 22'd0) begin n_bad++; $display("FAIL reset: sel=%0d busy=%b done=%b result=%h, want all 0", sel, busy, done, result); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL reset_idle: busy=%b done=%b want 00", busy, done); end
  endtask
  task automatic test_basic;
    kick(16'h0005, 16'hFFFF);
    chan_en = 16'hFFFF;
    n_cmp++; if (sel !== 4'd0 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_first: sel=%0d busy=%b want 0/1", sel, busy); end
    for (int k = 1; k <= 8; k++) begin
      if (k == 2) start = 1'b1;
      if (k == 3) start = 1'b0;
      @(negedge clk);
      n_cmp++; if (done !== (k == 6)) begin n_bad++; $display("FAIL basic_done k=%0d: done=%b want %b", k, done, k == 6); end
      if (k == 3) begin n_cmp++; if (sel !== 4'd2) begin n_bad++; $display("FAIL basic_sel: sel=%0d want 2", sel); end end
      if (k == 6) begin n_cmp++; if (result !== 16'h0005 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_result: result=%h busy=%b want 0005/0", result, busy); end end
    end
  endtask
  task automatic test_abort;
    kick(16'hFFFF, 16'hFFFF);
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL abort_idle: busy=%b done=%b want 0/0", busy, done); end
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (done !== 1'b0 || result !== 16'h0005) begin n_bad++; $display("FAIL abort_hold k=%0d: done=%b result=%h want 0/0005", k, done, result); end
    end
  endtask
  task automatic test_single15;
    int pulses = 0;
    kick(16'h8000, 16'h8000);
    n_cmp++; if (sel !== 4'd15) begin n_bad++; $display("FAIL ch15_sel: sel=%0d want 15", sel); end
    for (int k = 0; k < 20; k++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL ch15_pulses: got %0d want 1", pulses); end
    n_cmp++; if (result !== 16'h8000 || sel !== 4'd15) begin n_bad++; $display("FAIL ch15_result: result=%h sel=%0d want 8000/15", result, sel); end
  endtask
  task automatic test_async_reset;
    int t = -1;
    kick(16'hFFFF, 16'hFFFF);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (sel !== 4'd0 || busy !== 1'b0 || result !== 16'h0) begin n_bad++; $display("FAIL areset: sel=%0d busy=%b result=%h want 0/0/0", sel, busy, result); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL areset_idle: busy=%b want 0", busy); end
    kick(16'h0003, 16'h0002);
    for (int k = 1; k <= 20 && t < 0; k++) begin
      @(negedge clk);
      if (done) t = k;
    end
    n_cmp++; if (t != 6) begin n_bad++; $display("FAIL areset_rescan_time: done at %0d want 6", t); end
    n_cmp++; if (result !== 16'h0002) begin n_bad++; $display("FAIL areset_rescan: result=%h want 0002", result); end
  endtask
  task automatic test_zero_mask;
    kick(16'h0000, 16'hFFFF);
    n_cmp++; if (done !== 1'b1 || busy !== 1'b0 || result !== 16'h0) begin n_bad++; $display("FAIL zero: done=%b busy=%b result=%h want 1/0/0", done, busy, result); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL zero_after: done=%b busy=%b want 0/0", done, busy); end
  endtask
  task automatic test_start_abort;
    @(negedge clk);
    chan_en = 16'h0001;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL start_abort: busy=%b done=%b want 0/0", busy, done); end
  endtask
  initial begin
    test_reset;
    test_basic;
    test_abort;
    test_single15;
    test_async_reset;
    test_zero_mask;
    test_start_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
